mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RV32I memory-access stage between ex_mem and mem_wb. It passes ALU results through, and runs
//  loads and stores on a req/ack data bus with byte-lane alignment and load sign/zero extension.
//  It drives mem_wd/mem_wreg/mem_wdata into mem_wb and holds the upstream pipe with stall_req
//  while a bus access is outstanding.
// PARAMETERS
//  TIMEOUT    255  max cycles in BUSY without dbus_ack before abort
//  TIMEOUT_W  8    width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   reset, asynchronous, active-low
//  ex_valid       in   1   instruction in ex_mem is valid
//  ex_wd          in   5   destination register
//  ex_wreg        in   1   writes register file
//  ex_wdata       in   32  ALU result (address for load/store)
//  ex_is_load     in   1   instruction is LB/LH/LW/LBU/LHU
//  ex_is_store    in   1   instruction is SB/SH/SW
//  ex_funct3      in   3   RV32I funct3 (size/sign)
//  ex_store_data  in   32  rs2 value for stores
//  dbus_req       out  1   access request, held until ack
//  dbus_we        out  1   1 = write
//  dbus_addr      out  32  word address (addr[1:0] = 0)
//  dbus_be        out  4   byte enables
//  dbus_wdata     out  32  lane-aligned store data
//  dbus_ack       in   1   access complete; rdata valid same cycle
//  dbus_rdata     in   32  read word
//  stall_req      out  1   hold ex_mem and earlier stages
//  mem_wd         out  5   to mem_wb
//  mem_wreg       out  1   to mem_wb
//  mem_wdata      out  32  to mem_wb
//  bus_err        out  1   1-cycle pulse on timeout
//  misalign_exc   out  1   1-cycle pulse on misaligned access (macro only, else 0)
// BEHAVIOUR
//  - Reset (async): state IDLE, dbus_req/we=0, dbus_addr/be/wdata=0, timeout cnt=0,
//    bus_err=0, misalign_exc=0, load buffer=0. Reset mid-access drops dbus_req at once.
//  - FSM IDLE->BUSY->DONE->IDLE. Start condition: IDLE & ex_valid & (ex_is_load|ex_is_store).
//  - IDLE: if start, register the dbus_* outputs and go to BUSY. stall_req=1 combinationally that
//    cycle. Non-memory ops pass ex_wd/ex_wreg/ex_wdata straight through, with 0 added latency.
//  - BUSY: dbus_req=1 with stable addr/be/wdata/we; stall_req=1; counter increments.
//    On dbus_ack: capture the extended load data, deassert req next cycle, go to DONE.
//    At count==TIMEOUT with no ack: drop req, pulse bus_err, go to DONE with mem_wreg=0.
//  - DONE: stall_req=0; mem_wdata=captured load data; mem_wreg=ex_wreg&ex_is_load&~err;
//    no new access starts; go to IDLE unconditionally. Load latency to mem_wb = 3 cycles with
//    zero wait states.
//  - While stall_req=1, mem_wreg=0, so mem_wb captures bubbles. Stores always give mem_wreg=0.
//  - dbus_ack in IDLE or DONE is ignored.
//  - Store lanes: SB be=0001<<a[1:0], data={4{b}}. SH be=0011<<{a[1],0}, data={2{h}}. SW be=1111.
//  - Loads: LB/LH sign-extend, LBU/LHU zero-extend, using the selected lane of dbus_rdata.
//  - Misaligned: LH/LHU/SH with a[0]=1; LW/SW with a[1:0]!=0.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: a misaligned start does no bus access. The block pulses
//    misalign_exc for 1 cycle, forces mem_wreg=0, and asserts no stall.
//  MISALIGN_TRAP_EN undefined: the offending low address bits are cleared to natural alignment
//    and the access proceeds. misalign_exc is tied 0.
// STRUCTURE
//  - riscv_pkg: funct3 constants (F3_LB..F3_LHU, F3_SB..F3_SW), state encoding, bus width.
//  - Sub-module lsu_align (combinational): store be/wdata generation and load extraction/extension.
// TESTING
//  1 ADD x5 result 0x1234, no mem op -> mem_wd=5, mem_wreg=1, mem_wdata=0x1234 same cycle, no stall.
//  2 LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> stall for 3 cycles,
//    mem_wdata=0xDEADBEEF in DONE.
//  3 LB addr 0x103, rdata 0x80FF0000 -> mem_wdata 0xFFFFFF80. LBU same -> 0x00000080.
//  4 SB addr 0x102, rs2 0x000000A5 -> be=0100, wdata 0xA5A5A5A5, mem_wreg=0.
//  5 LW with no ack -> after TIMEOUT BUSY cycles bus_err=1 for 1 cycle, mem_wreg=0, back to IDLE.
//  6 LW addr 0x102 -> trap build: misalign_exc=1, dbus_req never set.
//    Non-trap build: dbus_addr=0x100, be=1111.
//  7 Assert rst_n low during BUSY -> dbus_req=0 immediately, state IDLE after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 encodings, stage FSM states,
// data bus width and the alignment helpers used by the load/store path.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return {addr_lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the memory stage: store byte enables / replicated write data,
// and load lane extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;

  assign shifted   = rdata >> {offset, 3'b000};
  assign lane_byte = shifted[7:0];
  assign lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_data = {24'd0, lane_byte};
      F3_LHU:  load_data = {16'd0, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: ALU pass-through plus req/ack load/store sequencing.
// Build option MISALIGN_TRAP_EN: misaligned accesses trap instead of being force-aligned.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_wd,
  input  logic            ex_wreg,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_ack,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            stall_req,
  output logic [4:0]      mem_wd,
  output logic            mem_wreg,
  output logic [XLEN-1:0] mem_wdata,
  output logic            bus_err,
  output logic            misalign_exc
);

  mem_state_e           state;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 err_flag;
  logic [XLEN-1:0]      load_buf;
  logic [2:0]           funct3_q;
  logic [1:0]           offset_q;

  logic            start;
  logic            go;
  logic [1:0]      offset_now;
  logic [2:0]      funct3_sel;
  logic [1:0]      offset_sel;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;

  assign start      = (state == ST_IDLE) && ex_valid && (ex_is_load || ex_is_store);
  assign offset_now = align_offset(ex_funct3, ex_wdata[1:0]);

`ifdef MISALIGN_TRAP_EN
  logic mis;
  assign mis = is_misaligned(ex_funct3, ex_wdata[1:0]);
  assign go  = start && !mis;
`else
  assign go           = start;
  assign misalign_exc = 1'b0;
`endif

  // One aligner serves both directions: live ex inputs while launching, latched ones while waiting
  assign funct3_sel = (state == ST_IDLE) ? ex_funct3  : funct3_q;
  assign offset_sel = (state == ST_IDLE) ? offset_now : offset_q;

  lsu_align u_align (
    .funct3     (funct3_sel),
    .offset     (offset_sel),
    .store_data (ex_store_data),
    .rdata      (dbus_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      err_flag   <= 1'b0;
      load_buf   <= '0;
      funct3_q   <= '0;
      offset_q   <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            dbus_req   <= 1'b1;
            dbus_we    <= ex_is_store;
            dbus_addr  <= {ex_wdata[XLEN-1:2], 2'b00};
            dbus_be    <= al_be;
            dbus_wdata <= al_wdata;
            funct3_q   <= ex_funct3;
            offset_q   <= offset_now;
            cnt        <= TIMEOUT_W'(1);
            err_flag   <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dbus_ack) begin
            load_buf <= al_load;
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            state    <= ST_DONE;
          end else if (cnt == TIMEOUT_W'(TIMEOUT)) begin
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            bus_err  <= 1'b1;
            err_flag <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_exc <= 1'b0;
    else        misalign_exc <= start && mis;
  end
`endif

  // Any memory op in ex_mem produces a bubble until its DONE cycle
  always_comb begin
    stall_req = go || (state == ST_BUSY);
    mem_wd    = ex_wd;
    mem_wdata = ex_wdata;
    mem_wreg  = 1'b0;
    case (state)
      ST_IDLE: mem_wreg = ex_valid && ex_wreg && !start;
      ST_DONE: begin
        mem_wdata = load_buf;
        mem_wreg  = ex_wreg && ex_is_load && !err_flag;
      end
      default: mem_wreg = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of ALU/load/store transactions plus hand
// sequences for timeout, async reset mid-access, idle ack and misalignment.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_store_data;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stall_req;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        bus_err;
  logic        misalign_exc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_wd         (ex_wd),
    .ex_wreg       (ex_wreg),
    .ex_wdata      (ex_wdata),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_funct3     (ex_funct3),
    .ex_store_data (ex_store_data),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_be       (dbus_be),
    .dbus_wdata    (dbus_wdata),
    .dbus_ack      (dbus_ack),
    .dbus_rdata    (dbus_rdata),
    .stall_req     (stall_req),
    .mem_wd        (mem_wd),
    .mem_wreg      (mem_wreg),
    .mem_wdata     (mem_wdata),
    .bus_err       (bus_err),
    .misalign_exc  (misalign_exc)
  );

  typedef struct {
    string       name;
    logic        is_load;
    logic        is_store;
    logic [2:0]  f3;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_at;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_bus_wdata;
    logic [31:0] exp_mem_wdata;
    logic        exp_mem_wreg;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_instr(input vec_t v);
    ex_valid      = 1'b1;
    ex_is_load    = v.is_load;
    ex_is_store   = v.is_store;
    ex_funct3     = v.f3;
    ex_wd         = v.wd;
    ex_wreg       = v.wreg;
    ex_wdata      = v.wdata;
    ex_store_data = v.sdata;
    dbus_ack      = 1'b0;
  endtask

  task automatic clear_instr();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  stalls;
    int  k;
    bit  acked;
    @(posedge clk); #1;
    drive_instr(v);
    @(negedge clk);
    if (!v.is_load && !v.is_store) begin
      check({v.name, ".stall"},     32'(stall_req), 32'd0);
      check({v.name, ".mem_wd"},    32'(mem_wd),    32'(v.wd));
      check({v.name, ".mem_wreg"},  32'(mem_wreg),  32'(v.exp_mem_wreg));
      check({v.name, ".mem_wdata"}, mem_wdata,      v.exp_mem_wdata);
      clear_instr();
      return;
    end
    check({v.name, ".idle_stall"}, 32'(stall_req), 32'd1);
    check({v.name, ".idle_wreg"},  32'(mem_wreg),  32'd0);
    stalls = 1;
    k      = 0;
    acked  = 1'b0;
    while (!acked && k < v.ack_at + 5) begin
      @(posedge clk); #1;
      k++;
      dbus_ack   = (k == v.ack_at);
      dbus_rdata = v.rdata;
      @(negedge clk);
      if (stall_req) stalls++;
      if (k == 1) begin
        check({v.name, ".req"},  32'(dbus_req), 32'd1);
        check({v.name, ".we"},   32'(dbus_we),  32'(v.is_store));
        check({v.name, ".addr"}, dbus_addr,     v.exp_addr);
        check({v.name, ".be"},   32'(dbus_be),  32'(v.exp_be));
        check({v.name, ".busy_wreg"}, 32'(mem_wreg), 32'd0);
        if (v.is_store) check({v.name, ".bus_wdata"}, dbus_wdata, v.exp_bus_wdata);
      end
      acked = dbus_ack;
    end
    if (!acked) check({v.name, ".ack_reached"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    dbus_ack   = 1'b0;
    dbus_rdata = '0;
    @(negedge clk);
    check({v.name, ".done_stall"}, 32'(stall_req), 32'd0);
    check({v.name, ".done_req"},   32'(dbus_req),  32'd0);
    check({v.name, ".done_wreg"},  32'(mem_wreg),  32'(v.exp_mem_wreg));
    check({v.name, ".stall_cyc"},  32'(stalls),    32'(v.exp_stall));
    if (v.is_load) check({v.name, ".load_data"}, mem_wdata, v.exp_mem_wdata);
    @(posedge clk); #1;
    clear_instr();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t mv;
    int   busy;

    // name, ld, st, f3, wd, wreg, ex_wdata, sdata, rdata, ack_at, addr, be, bus_wdata, mem_wdata, wreg, stalls
    vecs.push_back('{"add_x5",  0, 0, 3'b000,  5, 1, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 32'h0000_1234, 1, 0});
    vecs.push_back('{"lw_100",  1, 0, 3'b010,  6, 1, 32'h0000_0100, 0, 32'hDEAD_BEEF, 2, 32'h100, 4'b1111, 0, 32'hDEAD_BEEF, 1, 3});
    vecs.push_back('{"lb_103",  1, 0, 3'b000,  7, 1, 32'h0000_0103, 0, 32'h80FF_0000, 1, 32'h100, 4'b1000, 0, 32'hFFFF_FF80, 1, 2});
    vecs.push_back('{"lbu_103", 1, 0, 3'b100,  8, 1, 32'h0000_0103, 0, 32'h80FF_0000, 1, 32'h100, 4'b1000, 0, 32'h0000_0080, 1, 2});
    vecs.push_back('{"lb_101",  1, 0, 3'b000,  9, 1, 32'h0000_0101, 0, 32'h0000_7F00, 2, 32'h100, 4'b0010, 0, 32'h0000_007F, 1, 3});
    vecs.push_back('{"lh_102",  1, 0, 3'b001, 10, 1, 32'h0000_0102, 0, 32'h8001_1234, 3, 32'h100, 4'b1100, 0, 32'hFFFF_8001, 1, 4});
    vecs.push_back('{"lhu_100", 1, 0, 3'b101, 11, 1, 32'h0000_0100, 0, 32'h8001_F00D, 1, 32'h100, 4'b0011, 0, 32'h0000_F00D, 1, 2});
    vecs.push_back('{"sb_102",  0, 1, 3'b000,  0, 0, 32'h0000_0102, 32'h0000_00A5, 0, 1, 32'h100, 4'b0100, 32'hA5A5_A5A5, 0, 0, 2});
    vecs.push_back('{"sh_106",  0, 1, 3'b001,  3, 1, 32'h0000_0106, 32'h1234_BEEF, 0, 2, 32'h104, 4'b1100, 32'hBEEF_BEEF, 0, 0, 3});
    vecs.push_back('{"sw_108",  0, 1, 3'b010,  0, 0, 32'h0000_0108, 32'hCAFE_F00D, 0, 1, 32'h108, 4'b1111, 32'hCAFE_F00D, 0, 0, 2});
    vecs.push_back('{"add_x31", 0, 0, 3'b000, 31, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{"nop_wr0", 0, 0, 3'b000,  0, 0, 32'h0000_0055, 0, 0, 0, 0, 0, 0, 32'h0000_0055, 0, 0});

    rst_n = 1'b0;
    clear_instr();
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_funct3 = '0; ex_store_data = '0;
    dbus_ack = 1'b0; dbus_rdata = '0;

    @(negedge clk);
    check("reset.req",      32'(dbus_req),     32'd0);
    check("reset.we",       32'(dbus_we),      32'd0);
    check("reset.addr",     dbus_addr,         32'd0);
    check("reset.be",       32'(dbus_be),      32'd0);
    check("reset.wdata",    dbus_wdata,        32'd0);
    check("reset.bus_err",  32'(bus_err),      32'd0);
    check("reset.misalign", 32'(misalign_exc), 32'd0);
    check("reset.stall",    32'(stall_req),    32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // ack while idle must not start or disturb anything
    @(posedge clk); #1;
    dbus_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_ack.req",     32'(dbus_req),  32'd0);
    check("idle_ack.stall",   32'(stall_req), 32'd0);
    check("idle_ack.bus_err", 32'(bus_err),   32'd0);
    dbus_ack = 1'b0;

    // bus timeout: LW with no ack holds req for TIMEOUT busy cycles then aborts
    mv = '{"lw_to", 1, 0, 3'b010, 12, 1, 32'h0000_0200, 0, 0, 0, 32'h200, 4'b1111, 0, 0, 0, 0};
    @(posedge clk); #1;
    drive_instr(mv);
    @(negedge clk);
    busy = 0;
    while (busy < 400) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!dbus_req) break;
      busy++;
    end
    check("timeout.busy_cycles", 32'(busy),      32'd255);
    check("timeout.bus_err",     32'(bus_err),   32'd1);
    check("timeout.wreg",        32'(mem_wreg),  32'd0);
    check("timeout.stall",       32'(stall_req), 32'd0);
    @(posedge clk); #1;
    clear_instr();
    @(negedge clk);
    check("timeout.err_pulse", 32'(bus_err),  32'd0);
    check("timeout.idle_req",  32'(dbus_req), 32'd0);

    // async reset in the middle of an access
    mv = '{"lw_rst", 1, 0, 3'b010, 13, 1, 32'h0000_0300, 0, 0, 0, 32'h300, 4'b1111, 0, 0, 0, 0};
    @(posedge clk); #1;
    drive_instr(mv);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid.req_before", 32'(dbus_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.req_dropped", 32'(dbus_req), 32'd0);
    clear_instr();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.idle_req",   32'(dbus_req),  32'd0);
    check("rst_mid.idle_stall", 32'(stall_req), 32'd0);
    run_vec(vecs[1]);

`ifdef MISALIGN_TRAP_EN
    mv = '{"lw_mis", 1, 0, 3'b010, 14, 1, 32'h0000_0102, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    drive_instr(mv);
    @(negedge clk);
    check("mis.stall", 32'(stall_req), 32'd0);
    check("mis.wreg",  32'(mem_wreg),  32'd0);
    @(posedge clk); #1;
    clear_instr();
    @(negedge clk);
    check("mis.exc",     32'(misalign_exc), 32'd1);
    check("mis.req",     32'(dbus_req),     32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis.exc_end", 32'(misalign_exc), 32'd0);
    check("mis.req_end", 32'(dbus_req),     32'd0);
`else
    mv = '{"lw_mis", 1, 0, 3'b010, 14, 1, 32'h0000_0102, 0, 32'h1122_3344, 1, 32'h100, 4'b1111, 0, 32'h1122_3344, 1, 2};
    run_vec(mv);
    check("mis.exc_tied", 32'(misalign_exc), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
